// File: rtl/mems_scan_pkg.sv
// Shared types and elaboration helpers for the MEMS mirror scan sequencer.
// Holds the FSM state encoding, the last-scan-address computation and counter sizing.
package mems_scan_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StInit = 2'd1,
      StScan = 2'd2,
      StDone = 2'd3
   } state_e;

   function automatic longint unsigned scan_last(input int unsigned base, input int unsigned ppl,
                                                 input int unsigned lpf, input int unsigned fc);
      return longint'(base) + longint'(ppl) * longint'(lpf) * longint'(fc) - 64'd1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mems_scan_sequencer_if.sv
// Sequencer-side bundle: DAC SPI request handshake plus the readout marker/ack pairs.
// The sequencer drives through the master modport; the SPI master/readout side uses slave.
interface mems_scan_sequencer_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              spi_start;
   logic [ADDR_W-1:0] addr;
   logic              spi_busy;
   logic              new_line;
   logic              new_frame;
   logic              line_ack;
   logic              frame_ack;

   modport master (
      output spi_start, addr, new_line, new_frame,
      input  spi_busy, line_ack, frame_ack
   );

   modport slave (
      input  spi_start, addr, new_line, new_frame,
      output spi_busy, line_ack, frame_ack
   );
endinterface

// File: rtl/mems_scan_counter.sv
// Cascaded point/line/frame position counter for the scan pattern.
// Decodes always describe the point about to be issued; step advances past it.
module mems_scan_counter
   import mems_scan_pkg::*;
#(
   parameter int unsigned POINTS_PER_LINE = 480,
   parameter int unsigned LINES_PER_FRAME = 14,
   parameter int unsigned FRAME_COUNT     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic step,
   output logic line_end,
   output logic frame_end,
   output logic pattern_end,
   output logic clear
);

   localparam int unsigned PW = cnt_w(POINTS_PER_LINE);
   localparam int unsigned LW = cnt_w(LINES_PER_FRAME);
   localparam int unsigned FW = cnt_w(FRAME_COUNT);

   localparam logic [PW-1:0] PointLast = PW'(POINTS_PER_LINE - 1);
   localparam logic [LW-1:0] LineLast  = LW'(LINES_PER_FRAME - 1);
   localparam logic [FW-1:0] FrameLast = FW'(FRAME_COUNT - 1);

   logic [PW-1:0] point_q, point_d;
   logic [LW-1:0] line_q, line_d;
   logic [FW-1:0] frame_q, frame_d;

   assign line_end    = (point_q == PointLast);
   assign frame_end   = line_end && (line_q == LineLast);
   assign pattern_end = frame_end && (frame_q == FrameLast);
   assign clear       = (point_q == '0) && (line_q == '0) && (frame_q == '0);

   always_comb begin
      point_d = point_q;
      line_d  = line_q;
      frame_d = frame_q;
      if (step) begin
         point_d = line_end ? '0 : point_q + 1'b1;
         if (line_end) begin
            line_d = frame_end ? '0 : line_q + 1'b1;
         end
         if (frame_end) begin
            frame_d = pattern_end ? '0 : frame_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         point_q <= '0;
         line_q  <= '0;
         frame_q <= '0;
      end else begin
         point_q <= point_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: rtl/mems_scan_sequencer.sv
// MEMS mirror scan sequencer: replays init commands, then walks the scan-point ROM region,
// issuing one SPI request per point and raising sticky line/frame markers for readout.
module mems_scan_sequencer
   import mems_scan_pkg::*;
#(
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned INIT_CMDS       = 2,
   parameter int unsigned SCAN_BASE       = 8,
   parameter int unsigned POINTS_PER_LINE = 480,
   parameter int unsigned LINES_PER_FRAME = 14,
   parameter int unsigned FRAME_COUNT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  single_shot,
   input  logic                  pause,
   mems_scan_sequencer_if.master bus,
   output logic                  marker_overrun,
   output logic                  scanning,
   output logic                  done
);

   localparam longint unsigned ScanLast =
      scan_last(SCAN_BASE, POINTS_PER_LINE, LINES_PER_FRAME, FRAME_COUNT);
   localparam longint unsigned AddrSpan = 64'd1 << ADDR_W;

   if (ScanLast >= AddrSpan) begin : g_addr_chk
      $error("mems_scan_sequencer: scan pattern does not fit in ADDR_W");
   end
   if (INIT_CMDS < 1 || INIT_CMDS > SCAN_BASE) begin : g_init_chk
      $error("mems_scan_sequencer: INIT_CMDS must be 1..SCAN_BASE");
   end

   localparam logic [ADDR_W-1:0] InitLast = ADDR_W'(INIT_CMDS - 1);
   localparam logic [ADDR_W-1:0] ScanBase = ADDR_W'(SCAN_BASE);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              start_q, start_d;
   logic              wrap_q, wrap_d;
   logic              new_line_q, new_line_d;
   logic              new_frame_q, new_frame_d;
   logic              overrun_q, overrun_d;
   logic              opp, step;
   logic              line_end, frame_end, pattern_end, clear;
   logic              set_line, set_frame;

   mems_scan_counter #(
      .POINTS_PER_LINE (POINTS_PER_LINE),
      .LINES_PER_FRAME (LINES_PER_FRAME),
      .FRAME_COUNT     (FRAME_COUNT)
   ) u_counter (
      .clk         (clk),
      .rst         (rst),
      .restart     (state_q == StIdle),
      .step        (step),
      .line_end    (line_end),
      .frame_end   (frame_end),
      .pattern_end (pattern_end),
      .clear       (clear)
   );

   // A request may only go out while the SPI master is idle and our last pulse has dropped.
   assign opp = !bus.spi_busy && !start_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      start_d = 1'b0;
      step    = 1'b0;
      wrap_d  = wrap_q;
      unique case (state_q)
         StIdle: begin
            addr_d = '0;
            wrap_d = 1'b0;
            if (enable) begin
               state_d = StInit;
               start_d = 1'b1;
            end
         end
         StInit: begin
            if (opp) begin
               if (!enable) begin
                  state_d = StIdle;
                  addr_d  = '0;
               end else begin
                  start_d = 1'b1;
                  if (addr_q == InitLast) begin
                     addr_d  = ScanBase;
                     step    = 1'b1;
                     state_d = StScan;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
         end
         StScan: begin
            if (opp) begin
               if (!enable) begin
                  state_d = StIdle;
                  addr_d  = '0;
               end else if (wrap_q && single_shot) begin
                  state_d = StDone;
               end else if (!pause) begin
                  start_d = 1'b1;
                  step    = 1'b1;
                  addr_d  = clear ? ScanBase : addr_q + 1'b1;
               end
            end
         end
         StDone: begin
            if (!enable) begin
               state_d = StIdle;
               addr_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      // Remember that the pattern's final point has gone out until the next decision.
      if (step) begin
         wrap_d = pattern_end;
      end
   end

   assign set_line  = step && line_end && !frame_end;
   assign set_frame = step && frame_end;

   always_comb begin
      new_line_d  = set_line  || (new_line_q  && !bus.line_ack);
      new_frame_d = set_frame || (new_frame_q && !bus.frame_ack);
      overrun_d   = overrun_q || (set_line && new_line_q) || (set_frame && new_frame_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         start_q     <= 1'b0;
         wrap_q      <= 1'b0;
         new_line_q  <= 1'b0;
         new_frame_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         start_q     <= start_d;
         wrap_q      <= wrap_d;
         new_line_q  <= new_line_d;
         new_frame_q <= new_frame_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.spi_start  = start_q;
   assign bus.addr       = addr_q;
   assign bus.new_line   = new_line_q;
   assign bus.new_frame  = new_frame_q;
   assign marker_overrun = overrun_q;
   assign scanning       = (state_q == StScan);
   assign done           = (state_q == StDone);

endmodule
